// File: rtl/imem_loader.sv
// Byte-serial instruction-memory loader: length-prefixed big-endian word stream -> imem writes,
// holding the CPU in reset until the load completes. Optional trailing XOR checksum: LOADER_CHECKSUM_EN.
module imem_loader #(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [31:0]       wdata,
  output logic              cpu_reset,
  output logic              busy,
  output logic              done,
  output logic              error
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LEN_HI = 3'd1,
    S_LEN_LO = 3'd2,
    S_DATA   = 3'd3,
    S_WRITE  = 3'd4,
    S_DONE   = 3'd5,
    S_ERR    = 3'd6
`ifdef LOADER_CHECKSUM_EN
    , S_CHK  = 3'd7
`endif
  } state_t;

  // Largest legal word count; 17 bits so that 2^16 itself is representable.
  localparam logic [16:0] CAP = 17'd1 << ADDR_W;

  state_t            state_r;
  logic [7:0]        len_hi_r;
  logic [ADDR_W-1:0] last_idx_r;
  logic [ADDR_W-1:0] idx_r;
  logic [1:0]        byte_cnt_r;
  logic [23:0]       asm_r;
  logic [15:0]       len_s;
  logic              len_bad_s;
  logic              accept_s;

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] chk_r;

  function automatic logic [7:0] xor_accum(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction
`endif

  assign accept_s  = rx_valid & rx_ready;
  assign len_s     = {len_hi_r, rx_data};
  assign len_bad_s = (len_s == 16'd0) || ({1'b0, len_s} > CAP);

  // Byte acceptance is decided by the state alone.
  always_comb begin
    case (state_r)
      S_LEN_HI, S_LEN_LO, S_DATA: rx_ready = 1'b1;
`ifdef LOADER_CHECKSUM_EN
      S_CHK:                      rx_ready = 1'b1;
`endif
      default:                    rx_ready = 1'b0;
    endcase
  end

  // Load sequencer with registered memory-port and status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= S_IDLE;
      len_hi_r   <= 8'd0;
      last_idx_r <= '0;
      idx_r      <= '0;
      byte_cnt_r <= 2'd0;
      asm_r      <= 24'd0;
      we         <= 1'b0;
      waddr      <= '0;
      wdata      <= 32'd0;
      cpu_reset  <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      chk_r      <= 8'd0;
`endif
    end else begin
      we <= 1'b0;
      case (state_r)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            state_r   <= S_LEN_HI;
            busy      <= 1'b1;
            done      <= 1'b0;
            error     <= 1'b0;
            cpu_reset <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
            chk_r     <= 8'd0;
`endif
          end
        end
        S_LEN_HI: begin
          if (accept_s) begin
            len_hi_r <= rx_data;
            state_r  <= S_LEN_LO;
          end
        end
        S_LEN_LO: begin
          if (accept_s) begin
            if (len_bad_s) begin
              state_r <= S_ERR;
              busy    <= 1'b0;
              error   <= 1'b1;
            end else begin
              last_idx_r <= ADDR_W'(len_s - 16'd1);
              idx_r      <= '0;
              byte_cnt_r <= 2'd0;
              state_r    <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (accept_s) begin
            asm_r <= {asm_r[15:0], rx_data};
`ifdef LOADER_CHECKSUM_EN
            chk_r <= xor_accum(chk_r, rx_data);
`endif
            if (byte_cnt_r == 2'd3) begin
              byte_cnt_r <= 2'd0;
              we         <= 1'b1;
              waddr      <= idx_r;
              wdata      <= {asm_r, rx_data};
              state_r    <= S_WRITE;
            end else begin
              byte_cnt_r <= byte_cnt_r + 2'd1;
            end
          end
        end
        S_WRITE: begin
          if (idx_r == last_idx_r) begin
`ifdef LOADER_CHECKSUM_EN
            state_r   <= S_CHK;
`else
            state_r   <= S_DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
            cpu_reset <= 1'b0;
`endif
          end else begin
            idx_r   <= idx_r + ADDR_W'(1);
            state_r <= S_DATA;
          end
        end
`ifdef LOADER_CHECKSUM_EN
        S_CHK: begin
          if (accept_s) begin
            busy <= 1'b0;
            if (rx_data == chk_r) begin
              state_r   <= S_DONE;
              done      <= 1'b1;
              cpu_reset <= 1'b0;
            end else begin
              state_r <= S_ERR;
              error   <= 1'b1;
            end
          end
        end
`endif
        default: begin
          state_r   <= S_IDLE;
          busy      <= 1'b0;
          cpu_reset <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed and randomized loads against a word-list model.
module tb_imem_loader;
  localparam int ADDR_W = 6;
  localparam int CAP    = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              reset, start, rx_valid;
  logic [7:0]        rx_data;
  logic              rx_ready, we, cpu_reset, busy, done, error;
  logic [ADDR_W-1:0] waddr;
  logic [31:0]       wdata;

  int total = 0;
  int bad   = 0;

  logic [31:0]       words[$];
  logic [ADDR_W-1:0] wlog_a[$];
  logic [31:0]       wlog_d[$];
  int                consec_we = 0;
  logic              we_prev   = 1'b0;

  imem_loader #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .start(start), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_ready(rx_ready), .we(we), .waddr(waddr), .wdata(wdata),
    .cpu_reset(cpu_reset), .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  // Write-port monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (we) begin
      wlog_a.push_back(waddr);
      wlog_d.push_back(wdata);
      if (we_prev) consec_we++;
    end
    we_prev = we;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Present one byte until accepted; with jitter, rx_valid drops randomly and data is garbage while invalid.
  task automatic send_byte(input logic [7:0] b, input bit jitter);
    bit sent = 1'b0;
    int guard = 0;
    while (!sent && guard < 100) begin
      rx_valid = jitter ? ($urandom_range(0, 2) != 0) : 1'b1;
      rx_data  = rx_valid ? b : 8'($urandom);
      sent     = rx_valid && rx_ready;
      @(negedge clk);
      guard++;
    end
    rx_valid = 1'b0;
    if (!sent) check_bit("byte_timeout", 1'b0, 1'b1);
  endtask

  // One full load session of the current words[] list, judged against the stream rules.
  task automatic run_load(input int n, input bit jitter, input bit mid_start,
                          input bit use_cs, input logic [7:0] cs_byte);
    logic [15:0] len = 16'(n);
    logic [7:0]  x = 8'h00;
    logic [7:0]  b;
    bit          ok;
    int          waits = 0;
    wlog_a.delete();
    wlog_d.delete();
    consec_we = 0;
    pulse_start();
    check_bit("busy_after_start", busy, 1'b1);
    check_bit("cpu_reset_after_start", cpu_reset, 1'b1);
    check_bit("done_cleared", done, 1'b0);
    send_byte(len[15:8], jitter);
    send_byte(len[7:0], jitter);
    if (n == 0 || n > CAP) begin
      check_bit("len_err_error", error, 1'b1);
      check_bit("len_err_cpu_reset", cpu_reset, 1'b1);
      check_bit("len_err_rx_ready", rx_ready, 1'b0);
      check_bit("len_err_busy", busy, 1'b0);
      repeat (4) @(negedge clk);
      check("len_err_no_write", 32'(wlog_a.size()), 32'd0);
      return;
    end
    for (int i = 0; i < n; i++) begin
      for (int k = 0; k < 4; k++) begin
        b = words[i][31 - 8*k -: 8];
        x ^= b;
        send_byte(b, jitter);
        if (k == 3) check_bit("we_latency", we, 1'b1);
        if (mid_start && i == 1 && k == 1) begin
          pulse_start();
          check_bit("mid_start_busy", busy, 1'b1);
        end
      end
    end
    ok = 1'b1;
`ifdef LOADER_CHECKSUM_EN
    if (use_cs) begin
      send_byte(cs_byte, jitter);
      ok = (cs_byte == x);
    end else begin
      send_byte(x, jitter);
    end
`endif
    while (!(done || error) && waits < 20) begin
      @(negedge clk);
      waits++;
    end
`ifdef LOADER_CHECKSUM_EN
    check("finish_latency", 32'(waits), 32'd0);
`else
    check("finish_latency", 32'(waits), 32'd1);
`endif
    check_bit("end_done", done, ok);
    check_bit("end_error", error, !ok);
    check_bit("end_cpu_reset", cpu_reset, !ok);
    check_bit("end_busy", busy, 1'b0);
    check_bit("end_rx_ready", rx_ready, 1'b0);
    check("write_count", 32'(wlog_a.size()), 32'(n));
    for (int i = 0; i < n && i < wlog_a.size(); i++) begin
      check($sformatf("waddr[%0d]", i), 32'(wlog_a[i]), 32'(i));
      check($sformatf("wdata[%0d]", i), wlog_d[i], words[i]);
    end
    check("we_not_back_to_back", 32'(consec_we), 32'd0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    check_bit("rst_cpu_reset", cpu_reset, 1'b1);
    check_bit("rst_we", we, 1'b0);
    check_bit("rst_busy", busy, 1'b0);
    check_bit("rst_done", done, 1'b0);
    check_bit("rst_error", error, 1'b0);
    check_bit("rst_rx_ready", rx_ready, 1'b0);
    check("rst_waddr", 32'(waddr), 32'd0);
    check("rst_wdata", wdata, 32'd0);

    // Directed two-word program.
    words = '{32'h20080005, 32'hAC080004};
    run_load(2, 1'b0, 1'b0, 1'b0, 8'h00);

    // Illegal lengths: zero and one past capacity.
    words.delete();
    run_load(0, 1'b0, 1'b0, 1'b0, 8'h00);
    run_load(CAP + 1, 1'b0, 1'b0, 1'b0, 8'h00);

    // Three words with random rx_valid gaps and a stray start mid-load.
    words.delete();
    for (int i = 0; i < 3; i++) words.push_back($urandom);
    run_load(3, 1'b1, 1'b1, 1'b0, 8'h00);

    // Full-capacity load.
    words.delete();
    for (int i = 0; i < CAP; i++) words.push_back($urandom);
    run_load(CAP, 1'b0, 1'b0, 1'b0, 8'h00);

    // A few short random loads.
    for (int r = 0; r < 3; r++) begin
      int n = $urandom_range(1, 6);
      words.delete();
      for (int i = 0; i < n; i++) words.push_back($urandom);
      run_load(n, 1'b1, 1'b0, 1'b0, 8'h00);
    end

    // Reset after two bytes of the second word, then a fresh one-word load.
    pulse_start();
    send_byte(8'h00, 1'b0);
    send_byte(8'h02, 1'b0);
    send_byte(8'h11, 1'b0); send_byte(8'h22, 1'b0); send_byte(8'h33, 1'b0); send_byte(8'h44, 1'b0);
    send_byte(8'h55, 1'b0); send_byte(8'h66, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_bit("midrst_busy", busy, 1'b0);
    check_bit("midrst_cpu_reset", cpu_reset, 1'b1);
    check_bit("midrst_rx_ready", rx_ready, 1'b0);
    check_bit("midrst_done", done, 1'b0);
    words = '{32'h08000011};
    run_load(1, 1'b0, 1'b0, 1'b0, 8'h00);

`ifdef LOADER_CHECKSUM_EN
    words = '{32'h8C090000};
    run_load(1, 1'b0, 1'b0, 1'b1, 8'h85);
    run_load(1, 1'b0, 1'b0, 1'b1, 8'h00);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Byte-serial program loader. Receives a length-prefixed stream of MIPS instruction words and writes them into instruction memory.
- Holds the CPU in reset until the load completes, then releases it. The core's decoder then fetches and decodes the loaded words.
- Sits between a byte source (UART receiver or testbench) and the imem write port.

Parameters:
- ADDR_W, 6, imem word-address width; capacity = 2^ADDR_W words.

Ports:
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  single-cycle pulse; begins a load session
- rx_valid  in  1  rx_data holds a valid byte
- rx_data  in  8  incoming byte
- rx_ready  out  1  loader accepts a byte this cycle
- we  out  1  imem write strobe, one cycle per word
- waddr  out  ADDR_W  imem word address
- wdata  out  32  instruction word to write
- cpu_reset  out  1  holds the CPU core in reset
- busy  out  1  load session in progress
- done  out  1  last load completed successfully (sticky)
- error  out  1  last load failed (sticky)

Behaviour:
- Reset values: state=IDLE, rx_ready=0, we=0, waddr=0, wdata=0, cpu_reset=1, busy=0, done=0, error=0. Reset mid-load aborts immediately. No partial state survives. Words already written stay in imem.
- Handshake: a byte is accepted on a cycle where rx_valid && rx_ready. rx_ready is combinational from state: 1 only in LEN_HI, LEN_LO, DATA (and CHK with the option enabled).
- Stream format: 16-bit word count N (high byte first), then N words. Each word is 4 bytes, MSB first (big-endian, matching the core).
- States:
  - IDLE: cpu_reset=1. start -> LEN_HI, clearing done and error and setting busy.
  - LEN_HI: accept byte into len[15:8] -> LEN_LO.
  - LEN_LO: accept byte into len[7:0].
    - If N==0 or N>2^ADDR_W -> ERR.
    - Else -> DATA, with word index=0 and byte counter=0.
  - DATA: each accepted byte shifts into a 32-bit assembler (first byte lands in [31:24]). On the 4th byte -> WRITE.
  - WRITE: exactly one cycle. we=1, waddr=index, wdata=assembled word. rx_ready=0.
    - If index==N-1 -> DONE (or CHK).
    - Else index+1 -> DATA.
  - DONE: busy=0, done=1, cpu_reset=0. start -> LEN_HI (cpu_reset reasserted the next cycle).
  - ERR: busy=0, error=1, cpu_reset=1. start -> LEN_HI.
- start is ignored while busy=1.
- Bytes presented while rx_ready=0 are not consumed; the source must hold them.
- we is high only in WRITE, never two consecutive cycles. Minimum 5 cycles per word.
- Latency: 4th byte accepted at cycle t -> we=1 at t+1. Last WRITE at t -> done=1 and cpu_reset=0 at t+1.
- Index and byte counters never wrap. The length check guarantees index ≤ 2^ADDR_W−1.

Optional Feature:
- Macro: LOADER_CHECKSUM_EN.
- Defined:
  - A running XOR of all data bytes (length bytes excluded) is kept, cleared on start.
  - After the last WRITE the loader enters CHK and accepts one more byte.
  - Byte equals running XOR -> DONE; otherwise -> ERR (cpu_reset stays 1).
- Undefined: no CHK state; last WRITE -> DONE directly; no checksum logic.

Test Plan:
- Reset then idle 10 cycles -> cpu_reset=1, we=0, busy=0, done=0, error=0, rx_ready=0.
- start; bytes 00 02 | 20 08 00 05 | AC 08 00 04 -> we pulses with (waddr 0, wdata 0x20080005) and (waddr 1, wdata 0xAC080004). Then done=1, cpu_reset=0, busy=0.
- start; length 00 00, and separately 00 41 with ADDR_W=6 -> error=1, cpu_reset=1, no we pulse, rx_ready=0 after the length.
- rx_valid toggled randomly during a 3-word load, and start pulsed mid-load -> same imem contents as back-to-back delivery; start has no effect; no byte lost or duplicated.
- Reset asserted after 2 data bytes of word 1, then a fresh 1-word load 00 01 08 00 00 11 -> single write at waddr 0, wdata 0x08000011, done=1.
- LOADER_CHECKSUM_EN defined: 1-word load 8C 09 00 00 followed by 85 -> done=1. The same load followed by 00 -> error=1, cpu_reset=1.
